// File: rtl/normalize_if.sv
// normalize_if: bus between a product source and the normalize stage
//   in_valid     : prdt is valid this cycle
//   prdt         : 48-bit unsigned product of two 24-bit significands
//   out_valid    : adj_mantissa / norm_flag are valid this cycle
//   adj_mantissa : normalized fraction, hidden bit removed
//   norm_flag    : product was in [2,4), exponent must be incremented
interface normalize_if;
    logic        in_valid;
    logic [47:0] prdt;
    logic        out_valid;
    logic [22:0] adj_mantissa;
    logic        norm_flag;
    modport master (output in_valid, prdt, input out_valid, adj_mantissa, norm_flag);
    modport slave (input in_valid, prdt, output out_valid, adj_mantissa, norm_flag);
endinterface

// File: rtl/normalize.sv
// normalize: one-cycle significand-product normalizer with truncation
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : normalize_if slave (in_valid/prdt in, out_valid/adj_mantissa/norm_flag out)
module normalize (
    input logic        clk,
    input logic        rst,
    normalize_if.slave bus
);
    logic        valid_q;
    logic        flag_q, flag_d;
    logic [22:0] mant_q, mant_d;
    logic [22:0] unused_lo;
    // Product in [2,4) has its leading one at bit 47 and needs a right shift;
    // otherwise the leading one is at bit 46 (or absent for zero/denormal).
    always_comb begin
        flag_d = bus.prdt[47];
        mant_d = flag_d ? bus.prdt[46:24] : bus.prdt[45:23];
    end
    assign unused_lo = bus.prdt[22:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            flag_q  <= 1'b0;
            mant_q  <= 23'h0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                flag_q <= flag_d;
                mant_q <= mant_d;
            end
        end
    end
    assign bus.out_valid    = valid_q;
    assign bus.norm_flag    = flag_q;
    assign bus.adj_mantissa = mant_q;
endmodule

// File: tb/tb_normalize.sv
// tb_normalize: directed and random check of normalize against an arithmetic model
module tb_normalize;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    normalize_if bus ();
    normalize dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic        m_v;
    logic        m_f;
    logic [22:0] m_m;
    function automatic logic model_flag(logic [47:0] p);
        return p >= 48'h8000_0000_0000;
    endfunction
    function automatic logic [22:0] model_mant(logic [47:0] p);
        logic [47:0] s;
        s = model_flag(p) ? p / 48'd16777216 : p / 48'd8388608;
        return 23'(s % 48'd8388608);
    endfunction
    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v <= 1'b0;
            m_f <= 1'b0;
            m_m <= 23'h0;
        end else begin
            m_v <= bus.in_valid;
            if (bus.in_valid) begin
                m_f <= model_flag(bus.prdt);
                m_m <= model_mant(bus.prdt);
            end
        end
    end
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out_valid", 32'(bus.out_valid), 32'(m_v));
            chk("cyc_norm_flag", 32'(bus.norm_flag), 32'(m_f));
            chk("cyc_adj_mantissa", 32'(bus.adj_mantissa), 32'(m_m));
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(logic [47:0] p);
        bus.in_valid = 1'b1;
        bus.prdt = p;
        step();
    endtask
    task automatic expect_out(string n, logic v, logic f, logic [22:0] m);
        chk({n, "_valid"}, 32'(bus.out_valid), 32'(v));
        chk({n, "_flag"}, 32'(bus.norm_flag), 32'(f));
        chk({n, "_mant"}, 32'(bus.adj_mantissa), 32'(m));
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.prdt = 48'h0;
        #1 rst = 1'b1;
        #2;
        expect_out("reset", 1'b0, 1'b0, 23'h0);
        chk("model_B52D", 32'(model_mant(48'hB52D95AACD59)), 32'h352D95);
        chk("model_7FFF", 32'(model_mant(48'h7FFFFF800000)), 32'h7FFFFF);
        chk("model_FFFF_flag", 32'(model_flag(48'hFFFFFFFFFFFF)), 32'h1);
        step();
        expect_out("reset_clk", 1'b0, 1'b0, 23'h0);
        rst = 1'b0;
        cmp_en = 1'b1;
        step();
        send(48'hB52D95AACD59);
        expect_out("sc_B52D", 1'b1, 1'b1, 23'h352D95);
        send(48'h7FFFFF800000);
        expect_out("sc_7FFF", 1'b1, 1'b0, 23'h7FFFFF);
        send(48'h400000000000);
        expect_out("sc_one", 1'b1, 1'b0, 23'h000000);
        send(48'hFFFFFFFFFFFF);
        expect_out("sc_FFFF", 1'b1, 1'b1, 23'h7FFFFF);
        send(48'h000000000000);
        expect_out("sc_zero", 1'b1, 1'b0, 23'h000000);
        send(48'h2000_0080_0000);
        expect_out("sc_denorm", 1'b1, 1'b0, 23'h400001);
        send(48'h8000_0100_0000);
        expect_out("sc_two", 1'b1, 1'b1, 23'h000001);
        send(48'h1234_5678_9ABC);
        send(48'h9876_5432_10FE);
        send(48'h6000_0000_0000);
        send(48'hC000_0000_0000);
        expect_out("b2b_last", 1'b1, 1'b1, 23'h400000);
        bus.in_valid = 1'b0;
        bus.prdt = 48'h5555_5555_5555;
        step();
        expect_out("idle_hold", 1'b0, 1'b1, 23'h400000);
        step();
        expect_out("idle_hold2", 1'b0, 1'b1, 23'h400000);
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.prdt = {16'($urandom), 32'($urandom)};
            step();
        end
        send(48'hB52D95AACD59);
        expect_out("pre_rst", 1'b1, 1'b1, 23'h352D95);
        bus.prdt = 48'hFFFFFFFFFFFF;
        #2 rst = 1'b1;
        #1;
        expect_out("async_rst", 1'b0, 1'b0, 23'h0);
        #1 rst = 1'b0;
        bus.in_valid = 1'b0;
        step();
        expect_out("post_rst_idle", 1'b0, 1'b0, 23'h0);
        send(48'h7FFFFF800000);
        expect_out("post_rst_first", 1'b1, 1'b0, 23'h7FFFFF);
        bus.in_valid = 1'b0;
        step();
        step();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
